// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus types, default widths and serial bit order
package bus_pkg;

  localparam int BUS_ADDR_W = 14;
  localparam int BUS_DATA_W = 8;

  // Serial order used by every bus agent (master ports, slave ports, arbiter)
  localparam bit BIT_LSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_ADDR       = 3'd2,
    S_WDATA      = 3'd3,
    S_RWAIT      = 3'd4,
    S_SPLIT_WAIT = 3'd5,
    S_DONE       = 3'd6
  } bus_state_e;

endpackage

// File: rtl/bus_serdes.sv
// rtl/bus_serdes.sv - shift register with bit counter, used as PISO and SIPO
module bus_serdes
  import bus_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          clear,
  input  logic          shift,
  input  logic [CW-1:0] len,
  input  logic          sin,
  output logic          sout,
  output logic          at_last,
  output logic [W-1:0]  data,
  output logic [W-1:0]  data_next
);

  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // at_last only looks at the count so callers can combine it with their own shift decision
  assign at_last   = (cnt_q == len - 1'b1);
  assign sout      = BIT_LSB_FIRST ? sreg_q[0] : sreg_q[W-1];
  assign data      = sreg_q;
  assign data_next = sreg_d;

  // Load has priority so a PISO can be reloaded on the cycle its last bit leaves
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load) begin
      sreg_d = load_data;
      cnt_d  = '0;
    end else if (clear) begin
      cnt_d  = '0;
    end else if (shift) begin
      if (BIT_LSB_FIRST) begin
        sreg_d = {sin, sreg_q[W-1:1]};
      end else begin
        sreg_d = {sreg_q[W-2:0], sin};
      end
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - initiator bus port with split/resume; watchdog under BUS_TIMEOUT_EN
module bus_master_port
  import bus_pkg::*;
#(
  parameter int MASTER_ID   = 0,
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              M_START,
  input  logic              M_RW,
  input  logic [ADDR_W-1:0] M_ADDR,
  input  logic [DATA_W-1:0] M_WDATA,
  output logic              M_BUSY,
  output logic [DATA_W-1:0] M_RDATA,
  output logic              M_DONE,
  output logic              M_ERR,
  output logic              B_REQ,
  input  logic              B_GRANT,
  output logic              B_UTIL,
  input  logic              B_SPLIT,
  input  logic              B_SPL_RESUME,
  output logic              B_DONE,
  output logic              B_MODE,
  output logic              B_TX,
  output logic              B_TX_VALID,
  input  logic              B_RX,
  input  logic              B_RX_VALID,
  input  logic              B_SREADY
);

  // Grant routing by index happens at the top level; the port itself is identity-free
  localparam int unused_master_id = MASTER_ID;

  localparam int TX_CW = $clog2(ADDR_W + 1);
  localparam int RX_CW = $clog2(DATA_W + 1);
  localparam logic [TX_CW-1:0] TX_LEN_ADDR = TX_CW'(ADDR_W);
  localparam logic [TX_CW-1:0] TX_LEN_DATA = TX_CW'(DATA_W);
  localparam logic [RX_CW-1:0] RX_LEN      = RX_CW'(DATA_W);

  bus_state_e        state_q, state_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              tx_load, tx_shift, tx_sout, tx_at_last;
  logic [ADDR_W-1:0] tx_load_data;
  logic [TX_CW-1:0]  tx_len;
  logic [ADDR_W-1:0] tx_data_unused, tx_next_unused;
  logic              rx_load, rx_clear, rx_shift, rx_at_last;
  logic              rx_sout_unused;
  logic [DATA_W-1:0] rx_data_unused, rx_next;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_wait;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  assign tx_len = (state_q == S_WDATA) ? TX_LEN_DATA : TX_LEN_ADDR;

  bus_serdes #(.W(ADDR_W)) u_tx (
    .CLK(CLK), .RSTN(RSTN),
    .load(tx_load), .load_data(tx_load_data), .clear(1'b0), .shift(tx_shift),
    .len(tx_len), .sin(1'b0), .sout(tx_sout), .at_last(tx_at_last),
    .data(tx_data_unused), .data_next(tx_next_unused)
  );

  bus_serdes #(.W(DATA_W)) u_rx (
    .CLK(CLK), .RSTN(RSTN),
    .load(rx_load), .load_data('0), .clear(rx_clear), .shift(rx_shift),
    .len(RX_LEN), .sin(B_RX), .sout(rx_sout_unused), .at_last(rx_at_last),
    .data(rx_data_unused), .data_next(rx_next)
  );

  assign B_REQ      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign B_UTIL     = (state_q == S_ADDR) || (state_q == S_WDATA) || (state_q == S_RWAIT);
  assign B_MODE     = B_UTIL & rw_q;
  assign B_TX_VALID = tx_shift;
  assign B_TX       = tx_shift & tx_sout;
  assign B_DONE     = (state_q == S_DONE);
  assign M_DONE     = (state_q == S_DONE);
  assign M_ERR      = err_q;
  assign M_BUSY     = (state_q != S_IDLE) || err_q;
  assign M_RDATA    = rdata_q;

  // Command sequencing; split outranks both a received bit and a dropped grant
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    tx_load      = 1'b0;
    tx_load_data = '0;
    tx_shift     = 1'b0;
    rx_load      = 1'b0;
    rx_clear     = 1'b0;
    rx_shift     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // err_q marks the abort-report cycle, which still counts as busy
        if (M_START && !err_q) begin
          rw_d         = M_RW;
          wdata_d      = M_WDATA;
          tx_load      = 1'b1;
          tx_load_data = M_ADDR;
          rx_load      = 1'b1;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (B_GRANT) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (B_GRANT) begin
          tx_shift = 1'b1;
          if (tx_at_last) begin
            if (rw_q) begin
              tx_load                   = 1'b1;
              tx_load_data[DATA_W-1:0] = wdata_q;
              state_d                   = S_WDATA;
            end else begin
              state_d = S_RWAIT;
            end
          end
        end else if (!B_SPLIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_WDATA: begin
        if (B_GRANT) begin
          if (B_SREADY) begin
            tx_shift = 1'b1;
            if (tx_at_last) state_d = S_DONE;
          end
        end else if (!B_SPLIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_RWAIT: begin
        if (B_SPLIT) begin
          rx_clear = 1'b1;
          state_d  = S_SPLIT_WAIT;
        end else if (!B_GRANT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (B_RX_VALID) begin
          rx_shift = 1'b1;
          if (rx_at_last) begin
            rdata_d = rx_next;
            state_d = S_DONE;
          end
        end
      end
      S_SPLIT_WAIT: begin
        if (B_GRANT && B_SPL_RESUME) state_d = S_RWAIT;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef BUS_TIMEOUT_EN
    // Counts only stalled cycles in a waiting state; any progress resets it
    to_wait = 1'b0;
    case (state_q)
      S_REQ:        to_wait = !B_GRANT;
      S_WDATA:      to_wait = B_GRANT && !B_SREADY;
      S_RWAIT:      to_wait = B_GRANT && !B_SPLIT && !B_RX_VALID;
      S_SPLIT_WAIT: to_wait = !(B_GRANT && B_SPL_RESUME);
      default:      to_wait = 1'b0;
    endcase
    to_cnt_d = to_wait ? to_cnt_q + 1'b1 : '0;
    if (to_wait && (to_cnt_d == TO_LIM)) begin
      to_cnt_d = '0;
      state_d  = S_IDLE;
      err_d    = 1'b1;
    end
`endif
  end

  // Control state registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Watchdog counter register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - directed self-checking bench for bus_master_port
module tb_bus_master_port;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
`ifdef BUS_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 255;
`endif

  logic              CLK = 1'b0;
  logic              RSTN;
  logic              M_START = 1'b0, M_RW = 1'b0;
  logic [ADDR_W-1:0] M_ADDR = '0;
  logic [DATA_W-1:0] M_WDATA = '0;
  logic              M_BUSY, M_DONE, M_ERR;
  logic [DATA_W-1:0] M_RDATA;
  logic              B_REQ, B_UTIL, B_DONE, B_MODE, B_TX, B_TX_VALID;
  logic              B_GRANT = 1'b0, B_SPLIT = 1'b0, B_SPL_RESUME = 1'b0;
  logic              B_RX = 1'b0, B_RX_VALID = 1'b0, B_SREADY = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [16:0] outs;
  assign outs = {M_BUSY, M_RDATA, M_DONE, M_ERR, B_REQ, B_UTIL, B_DONE, B_MODE, B_TX, B_TX_VALID};

  bus_master_port #(
    .MASTER_ID(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .M_START(M_START), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_BUSY(M_BUSY), .M_RDATA(M_RDATA), .M_DONE(M_DONE), .M_ERR(M_ERR),
    .B_REQ(B_REQ), .B_GRANT(B_GRANT), .B_UTIL(B_UTIL), .B_SPLIT(B_SPLIT),
    .B_SPL_RESUME(B_SPL_RESUME), .B_DONE(B_DONE), .B_MODE(B_MODE), .B_TX(B_TX),
    .B_TX_VALID(B_TX_VALID), .B_RX(B_RX), .B_RX_VALID(B_RX_VALID), .B_SREADY(B_SREADY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; samples are taken 4ns later
  task automatic go();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [7:0] d, input int gdelay,
                          output logic [21:0] c, output int dc);
    int n;
    n = 0; c = '0; dc = -1;
    M_START = 1'b1; M_RW = 1'b1; M_ADDR = a; M_WDATA = d;
    go();
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = 14'h3FFF; M_WDATA = 8'h00;
    for (int k = 0; k < gdelay; k++) begin
      B_GRANT = 1'b0;
      #4;
      if (k == 0) chk("req_state", {M_BUSY, B_REQ, B_UTIL}, 3'b110);
      go();
      M_START = 1'b0;
    end
    M_START = 1'b0;
    B_GRANT = 1'b1; B_SREADY = 1'b1;
    for (int i = 1; i <= 30 && dc < 0; i++) begin
      go();
      #4;
      if (B_TX_VALID) begin
        if (n < 22) c[n] = B_TX;
        n++;
      end
      if (B_DONE) dc = i;
    end
  endtask

  task automatic start_read(input logic [13:0] a, output logic [13:0] ca);
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = a;
    go();
    M_START = 1'b0; B_GRANT = 1'b1;
    ca = '0;
    for (int i = 0; i < 14; i++) begin
      go();
      #4;
      ca[i] = B_TX;
    end
    go();
  endtask

  logic [21:0] col;
  logic [13:0] ca;
  logic [7:0]  rd;
  int          dc;
  int          cnt;

  initial begin
    // Reset state
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    #2;
    chk("reset_outs", 32'(outs), 32'h0);
    go(); go();
    RSTN = 1'b1;
    #4;
    chk("idle_outs", 32'(outs), 32'h0);
    go();

    // Write 0x1A5 / 0xC3, grant after 3 REQ cycles; stray M_START while busy ignored
    do_write(14'h1A5, 8'hC3, 3, col, dc);
    chk("wr1_bits", 32'(col), 32'({8'hC3, 14'h1A5}));
    chk("wr1_done_cycle", 32'(dc), 32'd23);
    chk("wr1_done_state", {M_DONE, M_BUSY, B_REQ, B_UTIL, M_ERR}, 5'b11000);
    go();
    B_GRANT = 1'b0; B_SREADY = 1'b0;
    #4;
    chk("wr1_idle", {M_BUSY, M_DONE, B_DONE, B_REQ}, 4'b0000);
    go();

    // Read 0x0040, slave returns 0x5A with gaps
    start_read(14'h0040, ca);
    chk("rd1_addr", 32'(ca), 32'h0040);
    rd = 8'h5A; cnt = 0;
    for (int j = 0; j < 8; j++) begin
      if (j[0]) begin
        B_RX_VALID = 1'b0;
        #4;
        if (!B_UTIL || B_MODE) cnt++;
        go();
      end
      B_RX = rd[j]; B_RX_VALID = 1'b1;
      #4;
      if (!B_UTIL || B_MODE) cnt++;
      go();
    end
    B_RX_VALID = 1'b0;
    #4;
    chk("rd1_util_low", 32'(cnt), 32'd0);
    chk("rd1_done", {M_DONE, B_DONE, B_UTIL}, 3'b110);
    chk("rd1_rdata", 32'(M_RDATA), 32'h5A);
    go();
    B_GRANT = 1'b0;
    #4;
    chk("rd1_held", {M_BUSY, M_RDATA}, {1'b0, 8'h5A});
    go();

    // Read with split after 3 bits; split coincides with a data bit and grant loss
    start_read(14'h0123, ca);
    rd = 8'hA7;
    for (int j = 0; j < 3; j++) begin
      B_RX = rd[j]; B_RX_VALID = 1'b1;
      go();
    end
    B_SPLIT = 1'b1; B_RX = 1'b1; B_RX_VALID = 1'b1; B_GRANT = 1'b0;
    go();
    B_SPLIT = 1'b0; B_RX_VALID = 1'b0; B_GRANT = 1'b1; B_SPL_RESUME = 1'b0;
    #4;
    chk("split_wait", {B_UTIL, B_REQ, M_ERR, B_TX_VALID}, 4'b0100);
    go();
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #4;
      if (B_UTIL) cnt++;
      go();
    end
    chk("split_no_resume", 32'(cnt), 32'd0);
    B_SPL_RESUME = 1'b1;
    go();
    B_SPL_RESUME = 1'b0;
    #4;
    chk("split_resumed", {B_UTIL, B_REQ}, 2'b11);
    go();
    for (int j = 0; j < 8; j++) begin
      B_RX = rd[j]; B_RX_VALID = 1'b1;
      go();
    end
    B_RX_VALID = 1'b0;
    #4;
    chk("split_done", {M_DONE, B_DONE, M_ERR}, 3'b110);
    chk("split_rdata", 32'(M_RDATA), 32'hA7);
    go();
    B_GRANT = 1'b0;
    go();

    // Grant drops mid-address: abort, then a normal write
    M_START = 1'b1; M_RW = 1'b1; M_ADDR = 14'h0ABC; M_WDATA = 8'h11;
    go();
    M_START = 1'b0; B_GRANT = 1'b1; B_SREADY = 1'b1;
    for (int i = 0; i < 5; i++) go();
    #4;
    chk("abort_pre", {B_UTIL, B_MODE, B_TX_VALID}, 3'b111);
    go();
    B_GRANT = 1'b0;
    #4;
    chk("abort_cycle", {B_DONE, B_TX_VALID, M_ERR}, 3'b000);
    go();
    #4;
    chk("abort_err", {M_ERR, B_REQ, B_UTIL, B_DONE, M_DONE, M_BUSY}, 6'b100001);
    go();
    #4;
    chk("abort_idle", {M_ERR, M_BUSY, B_REQ}, 3'b000);
    go();
    do_write(14'h2001, 8'h5E, 0, col, dc);
    chk("wr2_bits", 32'(col), 32'({8'h5E, 14'h2001}));
    chk("wr2_done_cycle", 32'(dc), 32'd23);
    chk("wr2_done_state", {M_DONE, M_ERR}, 2'b10);
    go();
    B_GRANT = 1'b0; B_SREADY = 1'b0;
    go();

    // Reset asserted during WDATA
    M_START = 1'b1; M_RW = 1'b1; M_ADDR = 14'h1555; M_WDATA = 8'hFF;
    go();
    M_START = 1'b0; B_GRANT = 1'b1; B_SREADY = 1'b1;
    for (int i = 0; i < 17; i++) go();
    #2;
    chk("rst_in_wdata", {B_UTIL, B_MODE, B_TX_VALID, B_TX}, 4'b1111);
    RSTN = 1'b0;
    #1;
    chk("rst_async_outs", 32'(outs), 32'h0);
    go(); go();
    RSTN = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      #4;
      if (M_DONE || B_DONE || B_REQ || M_BUSY) cnt++;
      go();
    end
    chk("rst_no_done", 32'(cnt), 32'd0);
    B_GRANT = 1'b0; B_SREADY = 1'b0;
    go();

`ifdef BUS_TIMEOUT_EN
    // Grant never given: watchdog aborts after 16 REQ cycles
    M_START = 1'b1; M_RW = 1'b0; M_ADDR = 14'h0001;
    go();
    M_START = 1'b0;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      #4;
      if (B_REQ && !M_ERR) cnt++;
      go();
    end
    chk("to_req_cycles", 32'(cnt), 32'd16);
    #4;
    chk("to_abort", {M_ERR, B_REQ, B_UTIL}, 3'b100);
    go();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
